// File: rtl/argmax_stream_ctrl.sv
// ---------------------------------------------------------------------------
// argmax_stream_ctrl
//
// Purpose:
//   Sequencing controller for the classifier output stage. It takes the
//   final-layer class scores as a serial stream, one signed score per beat
//   with class 0 first, and keeps a running signed maximum. At frame end it
//   presents the index of the winning class on a valid/ready handshake.
//   It replaces a parallel compare tree when the FC layer emits one class
//   score at a time, and it sits between that layer and the result/UART logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   score beat valid
//   in_ready   out  controller can accept a beat (SCAN and not in reset)
//   in_data    in   signed class score, DATA_WIDTH bits two's complement
//   in_last    in   upstream marks final score of the frame
//   out_valid  out  prediction valid
//   out_ready  in   downstream accepts prediction
//   predict    out  winning class index, zero-extended to 32 bits
//   len_err    out  frame length mismatch, qualified by out_valid
//   frame_cnt  out  number of completed output handshakes (wraps)
// ---------------------------------------------------------------------------
module argmax_stream_ctrl #(
  parameter int DATA_WIDTH = 36,
  parameter int NUM_CLASS  = 10,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [31:0]           predict,
  output logic                         len_err,
  output logic        [15:0]           frame_cnt
);

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        max_idx;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [15:0]             frame_cnt_q;

  logic                    accept;
  logic                    at_last;
  logic                    frame_end;
  logic                    beat_wins;
  logic [IDX_W-1:0]        next_max_idx;
  logic signed [DATA_WIDTH-1:0] next_max_val;

  // in_ready is gated by rst_n so it reads 0 during the reset cycle itself,
  // regardless of whatever the state register held before the reset edge.
  assign in_ready = rst_n && (state == SCAN);
  assign accept   = in_valid && in_ready;
  assign at_last  = (idx == LAST_IDX);

  // The frame closes on whichever comes first: the upstream in_last marker
  // or the beat that fills the last class slot.
  assign frame_end = accept && (in_last || at_last);

  // Beat 0 always seeds the running maximum. Later beats only win on a
  // strict greater-than, so on a tie the lowest index is kept.
  assign beat_wins    = (idx == '0) || (in_data > max_val);
  assign next_max_idx = beat_wins ? idx : max_idx;
  assign next_max_val = beat_wins ? in_data : max_val;

  assign frame_cnt = frame_cnt_q;

  // Single sequential process for the whole controller. The final beat's
  // compare result is folded straight into predict so the prediction is
  // visible one cycle after that beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SCAN;
      idx         <= '0;
      max_idx     <= '0;
      max_val     <= '0;
      out_valid   <= 1'b0;
      predict     <= '0;
      len_err     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (accept) begin
            max_idx <= next_max_idx;
            max_val <= next_max_val;
            if (frame_end) begin
              state     <= HOLD;
              idx       <= '0;
              out_valid <= 1'b1;
              predict   <= {{(32-IDX_W){1'b0}}, next_max_idx};
              // A short frame (early in_last) and a full frame without
              // in_last are both flagged.
              len_err   <= (in_last != at_last);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        HOLD: begin
          // predict is left untouched on the handshake; it only changes at
          // the next frame end.
          if (out_ready) begin
            state       <= SCAN;
            out_valid   <= 1'b0;
            len_err     <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
